fifomem_sync: RTL and testbench

- Next-generation single-clock FIFO storage array: parametrised width, depth and byte-lane granularity.
- Adds registered read data with a valid flag, byte-lane write enables and selectable write/read collision policy.
- Adds an optional hardware clear sweep after reset.
- Sits under the synchronous FIFO controllers; pointer/flag logic drives waddr/raddr and the enables.

---
 rtl/fifomem_sync_if.sv | 38 +++
 rtl/fifomem_sync.sv | 132 +++++++++++++
 tb/tb_fifomem_sync.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifomem_sync_if.sv
// Request/response bundle between a synchronous FIFO controller and its
// storage array.
//   master : controller side, drives write/read requests and addresses
//   slave  : storage side, returns registered read data and status
// Signals:
//   wclken, wben[NBYTES], waddr, wdata : write request, lane enables, address, data
//   rclken, raddr                      : read request and address
//   rdata, rvalid                      : registered read word and its valid flag
//   ready                              : array usable (clear sweep finished)
//   busy_err                           : one-cycle pulse, request seen while not ready
interface fifomem_sync_if #(
  parameter int DATASIZE = 32,
  parameter int ADDRSIZE = 4,
  parameter int BYTESIZE = 8
);
  localparam int NBYTES = DATASIZE / BYTESIZE;

  logic                wclken;
  logic [NBYTES-1:0]   wben;
  logic [ADDRSIZE-1:0] waddr;
  logic [DATASIZE-1:0] wdata;
  logic                rclken;
  logic [ADDRSIZE-1:0] raddr;
  logic [DATASIZE-1:0] rdata;
  logic                rvalid;
  logic                ready;
  logic                busy_err;

  modport master (
    output wclken, wben, waddr, wdata, rclken, raddr,
    input  rdata, rvalid, ready, busy_err
  );

  modport slave (
    input  wclken, wben, waddr, wdata, rclken, raddr,
    output rdata, rvalid, ready, busy_err
  );
endinterface

// File: rtl/fifomem_sync.sv
// Single-clock FIFO storage array with byte-lane writes, registered read
// data plus valid flag, selectable same-address collision policy and an
// optional zeroing sweep after reset.
// Ports:
//   wclk   : single clock, all state updates on the rising edge
//   wrst_n : asynchronous active-low reset (control and output registers only;
//            the array itself is never reset, only swept)
//   bus    : fifomem_sync_if slave modport (requests in, rdata/rvalid/ready/busy_err out)
// Parameters:
//   DATASIZE, ADDRSIZE, DEPTH, BYTESIZE : geometry; DATASIZE multiple of BYTESIZE
//   WRFIRST        : 1 = colliding read returns the merged new word, 0 = old word
//   CLEAR_ON_RESET : 1 = write zero to every word after reset release
module fifomem_sync #(
  parameter int DATASIZE       = 32,
  parameter int ADDRSIZE       = 4,
  parameter int DEPTH          = 1 << ADDRSIZE,
  parameter int BYTESIZE       = 8,
  parameter int WRFIRST        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           wclk,
  input  logic           wrst_n,
  fifomem_sync_if.slave  bus
);

  localparam int NBYTES = DATASIZE / BYTESIZE;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state;
  logic [ADDRSIZE-1:0] clr_addr;
  logic                ready_r;
  logic                busy_r;

  logic [DATASIZE-1:0] mem [DEPTH];

  logic [NBYTES-1:0]   mem_we;
  logic [ADDRSIZE-1:0] mem_wa;
  logic [DATASIZE-1:0] mem_wd;

  logic [DATASIZE-1:0] rd_word_p0;
  logic [DATASIZE-1:0] rdata_p1;
  logic                vld_p1;

  // Overlay the enabled lanes of a new word onto an old word.
  function automatic logic [DATASIZE-1:0] lane_merge(
    input logic [DATASIZE-1:0] old_w,
    input logic [DATASIZE-1:0] new_w,
    input logic [NBYTES-1:0]   en
  );
    logic [DATASIZE-1:0] r;
    r = old_w;
    for (int i = 0; i < NBYTES; i++) begin
      if (en[i]) r[i*BYTESIZE +: BYTESIZE] = new_w[i*BYTESIZE +: BYTESIZE];
    end
    return r;
  endfunction

  // Control FSM: CLEAR sweeps the array once, RUN is terminal until reset.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      busy_r <= (bus.wclken | bus.rclken) & ~ready_r;
      case (state)
        CLEAR: begin
          if (CLEAR_ON_RESET == 0 || clr_addr == ADDRSIZE'(DEPTH - 1)) begin
            state   <= RUN;
            ready_r <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Write port mux: the sweep owns the array until ready. The sweep write is
  // also held off while reset is asserted so that clock edges during reset
  // leave the array untouched.
  always_comb begin
    mem_we = '0;
    mem_wa = bus.waddr;
    mem_wd = bus.wdata;
    if (state == CLEAR) begin
      if (CLEAR_ON_RESET != 0 && wrst_n) begin
        mem_we = '1;
        mem_wa = clr_addr;
        mem_wd = '0;
      end
    end else if (ready_r && bus.wclken) begin
      mem_we = bus.wben;
    end
  end

  always_ff @(posedge wclk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (mem_we[i]) mem[mem_wa][i*BYTESIZE +: BYTESIZE] <= mem_wd[i*BYTESIZE +: BYTESIZE];
    end
  end

  // Stage p0: read word selection, including write-first bypass on collision.
  always_comb begin
    rd_word_p0 = mem[bus.raddr];
    if (WRFIRST != 0 && bus.wclken && bus.waddr == bus.raddr) begin
      rd_word_p0 = lane_merge(mem[bus.raddr], bus.wdata, bus.wben);
    end
  end

  // Stage p1: registered read data and valid; data holds when no read occurs.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else if (ready_r && bus.rclken) begin
      rdata_p1 <= rd_word_p0;
      vld_p1   <= 1'b1;
    end else begin
      vld_p1   <= 1'b0;
    end
  end

  assign bus.rdata    = rdata_p1;
  assign bus.rvalid   = vld_p1;
  assign bus.ready    = ready_r;
  assign bus.busy_err = busy_r;

endmodule

// File: tb/tb_fifomem_sync.sv
// Bench for fifomem_sync: three instances share one stimulus stream
//   u0 : WRFIRST=1, CLEAR_ON_RESET=1
//   u1 : WRFIRST=0, CLEAR_ON_RESET=1
//   u2 : WRFIRST=1, CLEAR_ON_RESET=0 (status outputs only)
// A word-array reference model tracks the expected array and outputs.
module tb_fifomem_sync;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          wclken, rclken;
  logic [3:0]    wben;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata;

  int checks = 0;
  int errors = 0;

  fifomem_sync_if #(.DATASIZE(DW), .ADDRSIZE(AW), .BYTESIZE(8)) bus0 ();
  fifomem_sync_if #(.DATASIZE(DW), .ADDRSIZE(AW), .BYTESIZE(8)) bus1 ();
  fifomem_sync_if #(.DATASIZE(DW), .ADDRSIZE(AW), .BYTESIZE(8)) bus2 ();

  assign bus0.wclken = wclken; assign bus1.wclken = wclken; assign bus2.wclken = wclken;
  assign bus0.wben   = wben;   assign bus1.wben   = wben;   assign bus2.wben   = wben;
  assign bus0.waddr  = waddr;  assign bus1.waddr  = waddr;  assign bus2.waddr  = waddr;
  assign bus0.wdata  = wdata;  assign bus1.wdata  = wdata;  assign bus2.wdata  = wdata;
  assign bus0.rclken = rclken; assign bus1.rclken = rclken; assign bus2.rclken = rclken;
  assign bus0.raddr  = raddr;  assign bus1.raddr  = raddr;  assign bus2.raddr  = raddr;

  fifomem_sync #(.DATASIZE(DW), .ADDRSIZE(AW), .DEPTH(DEPTH), .BYTESIZE(8),
                 .WRFIRST(1), .CLEAR_ON_RESET(1)) u0 (.wclk(wclk), .wrst_n(wrst_n), .bus(bus0));
  fifomem_sync #(.DATASIZE(DW), .ADDRSIZE(AW), .DEPTH(DEPTH), .BYTESIZE(8),
                 .WRFIRST(0), .CLEAR_ON_RESET(1)) u1 (.wclk(wclk), .wrst_n(wrst_n), .bus(bus1));
  fifomem_sync #(.DATASIZE(DW), .ADDRSIZE(AW), .DEPTH(DEPTH), .BYTESIZE(8),
                 .WRFIRST(1), .CLEAR_ON_RESET(0)) u2 (.wclk(wclk), .wrst_n(wrst_n), .bus(bus2));

  always #5 wclk = ~wclk;

  // Reference model state
  logic [DW-1:0] mmem [DEPTH];
  int            edges;          // edges since reset release
  logic [DW-1:0] e_rd0, e_rd1;   // expected rdata for write-first / read-first
  logic          e_vld, e_busy, e_rdy;
  logic          e_vld2, e_busy2, e_rdy2;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [3:0] en);
    logic [DW-1:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = en[i] ? n[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  task automatic idle();
    wclken = 1'b0; rclken = 1'b0; wben = 4'h0; waddr = '0; raddr = '0; wdata = '0;
  endtask

  // Advance one clock edge, updating the model from the current inputs.
  task automatic cycle();
    logic rb, rb2;
    logic [DW-1:0] old;
    rb  = edges >= DEPTH;
    rb2 = edges >= 1;
    e_busy  = (wclken | rclken) && !rb;
    e_busy2 = (wclken | rclken) && !rb2;
    if (rb && rclken) begin
      old   = mmem[raddr];
      e_rd1 = old;
      e_rd0 = (wclken && waddr == raddr) ? merge(old, wdata, wben) : old;
      e_vld = 1'b1;
    end else begin
      e_vld = 1'b0;
    end
    e_vld2 = rb2 && rclken;
    if (rb && wclken) mmem[waddr] = merge(mmem[waddr], wdata, wben);
    else if (!rb) mmem[edges] = '0;
    edges++;
    e_rdy  = edges >= DEPTH;
    e_rdy2 = edges >= 1;
    @(posedge wclk); #1;
  endtask

  task automatic model_reset();
    edges = 0; e_rd0 = '0; e_rd1 = '0;
    e_vld = 0; e_busy = 0; e_rdy = 0; e_vld2 = 0; e_busy2 = 0; e_rdy2 = 0;
  endtask

  // Assert reset asynchronously, hold across one edge, release after it.
  task automatic pulse_reset();
    wrst_n = 1'b0;
    model_reset();
    @(posedge wclk); #1;
    wrst_n = 1'b1;
  endtask

  task automatic sweep_to_ready();
    idle();
    for (int k = 0; k < DEPTH; k++) cycle();
  endtask

  task automatic test_reset();
    idle();
    wrst_n = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({bus0.rdata, bus0.rvalid, bus0.ready, bus0.busy_err} !== {32'h0, 3'b000}) begin
      errors++; $display("FAIL reset_u0 got %h/%b/%b/%b want 0/0/0/0",
                         bus0.rdata, bus0.rvalid, bus0.ready, bus0.busy_err);
    end
    checks++;
    if ({bus2.rdata, bus2.rvalid, bus2.ready, bus2.busy_err} !== {32'h0, 3'b000}) begin
      errors++; $display("FAIL reset_u2 got %h/%b/%b/%b want 0/0/0/0",
                         bus2.rdata, bus2.rvalid, bus2.ready, bus2.busy_err);
    end
    @(posedge wclk); #1;
    wrst_n = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      cycle();
      checks++;
      if (bus0.ready !== e_rdy || bus1.ready !== e_rdy || e_rdy !== (k == DEPTH)) begin
        errors++; $display("FAIL sweep_ready edge %0d got %b/%b want %b", k, bus0.ready, bus1.ready, e_rdy);
      end
      checks++;
      if (bus2.ready !== e_rdy2) begin
        errors++; $display("FAIL noclear_ready edge %0d got %b want %b", k, bus2.ready, e_rdy2);
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      rclken = 1'b1; raddr = AW'(a);
      cycle();
      checks++;
      if (bus0.rdata !== 32'h0 || bus0.rvalid !== 1'b1 || bus1.rdata !== e_rd1) begin
        errors++; $display("FAIL cleared_read addr %0d got %h/%b want 00000000/1", a, bus0.rdata, bus0.rvalid);
      end
    end
    idle();
  endtask

  task automatic test_byte_lanes();
    idle();
    wclken = 1; wben = 4'b1111; waddr = 3; wdata = 32'hDEADBEEF; cycle();
    wben = 4'b0101; wdata = 32'h11223344; cycle();
    idle(); rclken = 1; raddr = 3; cycle();
    checks++;
    if (bus0.rdata !== 32'hDE22BE44 || bus0.rvalid !== 1'b1 || bus1.rdata !== 32'hDE22BE44) begin
      errors++; $display("FAIL byte_lanes got %h/%h want de22be44", bus0.rdata, bus1.rdata);
    end
    idle(); wclken = 1; wben = 4'b0000; waddr = 3; wdata = 32'hFFFFFFFF; cycle();
    idle(); rclken = 1; raddr = 3; cycle();
    checks++;
    if (bus0.rdata !== 32'hDE22BE44) begin
      errors++; $display("FAIL wben_zero got %h want de22be44", bus0.rdata);
    end
    idle();
  endtask

  task automatic test_collision();
    idle();
    wclken = 1; wben = 4'hF; waddr = 7; wdata = 32'h01020304; cycle();
    rclken = 1; raddr = 7; wdata = 32'hCAFEF00D; cycle();
    checks++;
    if (bus0.rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL collide_wrfirst got %h want cafef00d", bus0.rdata);
    end
    checks++;
    if (bus1.rdata !== 32'h01020304) begin
      errors++; $display("FAIL collide_rdfirst got %h want 01020304", bus1.rdata);
    end
    idle(); rclken = 1; raddr = 7; cycle();
    checks++;
    if (bus0.rdata !== 32'hCAFEF00D || bus1.rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL collide_after got %h/%h want cafef00d", bus0.rdata, bus1.rdata);
    end
    // partial-lane collision
    wclken = 1; wben = 4'b1001; waddr = 7; wdata = 32'h55667788; cycle();
    checks++;
    if (bus0.rdata !== 32'h55FEF088 || bus1.rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL collide_partial got %h/%h want 55fef088/cafef00d", bus0.rdata, bus1.rdata);
    end
    idle();
  endtask

  task automatic test_busy_during_sweep();
    idle();
    pulse_reset();
    for (int k = 1; k <= 4; k++) cycle();
    wclken = 1; wben = 4'hF; waddr = 1; wdata = 32'hFFFFFFFF; rclken = 1; raddr = 1;
    cycle();
    checks++;
    if (bus0.busy_err !== 1'b1 || bus1.busy_err !== e_busy || bus0.rvalid !== 1'b0) begin
      errors++; $display("FAIL busy_pulse got %b/%b want 1/0", bus0.busy_err, bus0.rvalid);
    end
    checks++;
    if (bus2.busy_err !== e_busy2 || bus2.rvalid !== e_vld2) begin
      errors++; $display("FAIL noclear_busy got %b/%b want %b/%b", bus2.busy_err, bus2.rvalid, e_busy2, e_vld2);
    end
    idle(); cycle();
    checks++;
    if (bus0.busy_err !== 1'b0) begin
      errors++; $display("FAIL busy_one_cycle got %b want 0", bus0.busy_err);
    end
    for (int k = 7; k <= DEPTH; k++) cycle();
    rclken = 1; raddr = 1; cycle();
    checks++;
    if (bus0.rdata !== 32'h0 || bus0.rdata !== e_rd0 || bus0.rvalid !== 1'b1) begin
      errors++; $display("FAIL busy_write_ignored got %h/%b want 00000000/1", bus0.rdata, bus0.rvalid);
    end
    idle();
  endtask

  task automatic test_reset_mid_sweep();
    idle();
    wclken = 1; wben = 4'hF; waddr = 2; wdata = 32'hAAAAAAAA; cycle();
    waddr = 12; cycle();
    idle();
    pulse_reset();
    for (int k = 1; k <= 8; k++) cycle();
    wrst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus0.ready !== 1'b0 || bus0.rvalid !== 1'b0 || bus0.rdata !== 32'h0) begin
      errors++; $display("FAIL async_reset got %b/%b/%h want 0/0/0", bus0.ready, bus0.rvalid, bus0.rdata);
    end
    @(posedge wclk); #1;
    wrst_n = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      cycle();
      checks++;
      if (bus0.ready !== e_rdy || e_rdy !== (k == DEPTH)) begin
        errors++; $display("FAIL restart_ready edge %0d got %b want %b", k, bus0.ready, e_rdy);
      end
    end
    rclken = 1; raddr = 2; cycle();
    checks++;
    if (bus0.rdata !== 32'h0) begin
      errors++; $display("FAIL restart_addr2 got %h want 00000000", bus0.rdata);
    end
    raddr = 12; cycle();
    checks++;
    if (bus0.rdata !== 32'h0 || bus1.rdata !== e_rd1) begin
      errors++; $display("FAIL restart_addr12 got %h want 00000000", bus0.rdata);
    end
    idle();
  endtask

  task automatic test_rvalid_hold();
    logic [DW-1:0] v;
    idle();
    v = $urandom;
    wclken = 1; wben = 4'hF; waddr = 9; wdata = v; cycle();
    idle(); rclken = 1; raddr = 9; cycle();
    checks++;
    if (bus0.rvalid !== 1'b1 || bus0.rdata !== v) begin
      errors++; $display("FAIL rvalid_pulse got %b/%h want 1/%h", bus0.rvalid, bus0.rdata, v);
    end
    idle();
    wclken = 1; wben = 4'hF; waddr = 9; wdata = ~v; raddr = 9;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (bus0.rvalid !== 1'b0 || bus0.rdata !== v || bus1.rdata !== v) begin
        errors++; $display("FAIL rdata_hold cyc %0d got %b/%h want 0/%h", k, bus0.rvalid, bus0.rdata, v);
      end
      wclken = 1'b0;
    end
    idle();
  endtask

  task automatic test_random();
    idle();
    for (int n = 0; n < 300; n++) begin
      wclken = 1'($urandom);
      rclken = 1'($urandom);
      wben   = 4'($urandom);
      waddr  = AW'($urandom_range(0, 3));
      raddr  = AW'($urandom_range(0, 3));
      wdata  = $urandom;
      cycle();
      checks++;
      if (bus0.rdata !== e_rd0 || bus0.rvalid !== e_vld || bus0.busy_err !== e_busy) begin
        errors++; $display("FAIL random_u0 n=%0d got %h/%b/%b want %h/%b/%b",
                           n, bus0.rdata, bus0.rvalid, bus0.busy_err, e_rd0, e_vld, e_busy);
      end
      checks++;
      if (bus1.rdata !== e_rd1 || bus1.rvalid !== e_vld) begin
        errors++; $display("FAIL random_u1 n=%0d got %h/%b want %h/%b", n, bus1.rdata, bus1.rvalid, e_rd1, e_vld);
      end
      checks++;
      if (bus2.rvalid !== e_vld2 || bus2.ready !== e_rdy2) begin
        errors++; $display("FAIL random_u2 n=%0d got %b/%b want %b/%b", n, bus2.rvalid, bus2.ready, e_vld2, e_rdy2);
      end
    end
    idle();
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) mmem[a] = '0;
    test_reset();
    test_byte_lanes();
    test_collision();
    test_busy_during_sweep();
    test_reset_mid_sweep();
    test_rvalid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
